// File: rtl/pe_incha_dual_ipacker_pkg.sv
// rtl/pe_incha_dual_ipacker_pkg.sv - shared PE types, state encodings and dimension helpers
package pe_incha_dual_ipacker_pkg;

   // Pairing state: EMPTY waits for an even ('a') pixel, HALF holds one.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } pack_state_t;

   // Output dimension of a conv-style PE layer. Chained layers use it to
   // derive their own IN_WIDTH/IN_HEIGHT from the previous layer.
   function automatic int pe_out_dim(input int in_dim, input int kernel,
                                     input int dilation, input int padding,
                                     input int stride);
      return (in_dim + 2 * padding - dilation * (kernel - 1) - 1) / stride + 1;
   endfunction

   // Counter width for a modulo-N counter, never narrower than one bit.
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/pe_incha_dual_ipacker_if.sv
// rtl/pe_incha_dual_ipacker_if.sv - pixel-in / pixel-pair-out bus (o_frame_last under PE_INCHA_DUAL_IPACKER_FRAME_LAST_EN)
interface pe_incha_dual_ipacker_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] o_data_a;
   logic [DATA_WIDTH-1:0] o_data_b;
   logic                  o_valid;
   logic                  o_half;
`ifdef PE_INCHA_DUAL_IPACKER_FRAME_LAST_EN
   logic                  o_frame_last;
`endif

   // Source of pixels / sink of pixel pairs.
   modport master (
      output i_data, i_valid,
      input  o_data_a, o_data_b, o_valid, o_half
`ifdef PE_INCHA_DUAL_IPACKER_FRAME_LAST_EN
      , input o_frame_last
`endif
   );

   // The packer itself.
   modport slave (
      input  i_data, i_valid,
      output o_data_a, o_data_b, o_valid, o_half
`ifdef PE_INCHA_DUAL_IPACKER_FRAME_LAST_EN
      , output o_frame_last
`endif
   );

endinterface

// File: rtl/pe_incha_dual_ipacker_frame_pixel_counter.sv
// rtl/pe_incha_dual_ipacker_frame_pixel_counter.sv - modulo-N pixel counter with terminal-count flag
module pe_incha_dual_ipacker_frame_pixel_counter
   import pe_incha_dual_ipacker_pkg::*;
#(
   parameter int MODULUS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tc
);
   localparam int CNT_W = cnt_width(MODULUS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

   logic [CNT_W-1:0] cnt;

   // tc flags the pixel currently being offered as the frame's final one.
   assign tc = (cnt == LAST);

   // Advance on each accepted pixel, wrapping so the next frame starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         if (tc) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_incha_dual_ipacker.sv
// rtl/pe_incha_dual_ipacker.sv - packs a pixel stream into even/odd pixel pairs (option: PE_INCHA_DUAL_IPACKER_FRAME_LAST_EN)
module pe_incha_dual_ipacker
   import pe_incha_dual_ipacker_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IN_WIDTH   = 513,
   parameter int IN_HEIGHT  = 257
) (
   input logic                    clk,
   input logic                    rst_n,
   pe_incha_dual_ipacker_if.slave bus
);
   localparam int PIXELS = IN_WIDTH * IN_HEIGHT;

   pack_state_t           state;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] data_a;
   logic [DATA_WIDTH-1:0] data_b;
   logic                  valid;
   logic                  half;
   logic                  frame_last;
   logic                  last_pix;

   pe_incha_dual_ipacker_frame_pixel_counter #(
      .MODULUS (PIXELS)
   ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.i_valid),
      .tc    (last_pix)
   );

   // Pairing FSM with registered beat outputs. An odd frame's final pixel
   // arrives in EMPTY and leaves alone as a half beat, so the next frame
   // always starts on an 'a' pixel without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         hold       <= '0;
         data_a     <= '0;
         data_b     <= '0;
         valid      <= 1'b0;
         half       <= 1'b0;
         frame_last <= 1'b0;
      end else begin
         valid      <= 1'b0;
         half       <= 1'b0;
         frame_last <= 1'b0;
         if (bus.i_valid) begin
            case (state)
               ST_EMPTY: begin
                  if (last_pix) begin
                     data_a     <= bus.i_data;
                     data_b     <= '0;
                     valid      <= 1'b1;
                     half       <= 1'b1;
                     frame_last <= 1'b1;
                  end else begin
                     hold  <= bus.i_data;
                     state <= ST_HALF;
                  end
               end
               ST_HALF: begin
                  data_a     <= hold;
                  data_b     <= bus.i_data;
                  valid      <= 1'b1;
                  frame_last <= last_pix;
                  state      <= ST_EMPTY;
               end
               default: state <= ST_EMPTY;
            endcase
         end
      end
   end

   assign bus.o_data_a = data_a;
   assign bus.o_data_b = data_b;
   assign bus.o_valid  = valid;
   assign bus.o_half   = half;

`ifdef PE_INCHA_DUAL_IPACKER_FRAME_LAST_EN
   assign bus.o_frame_last = frame_last;
`else
   logic unused_frame_last;
   assign unused_frame_last = frame_last;
`endif

endmodule
